// File: rtl/mult_accum.sv
// mult_accum: sums a programmable-length run of unsigned products into a
// wide total. A start/busy/done/ack handshake lets a controller collect
// dot-product style results instead of sampling the multiplier directly.

module mult_accum #(
    parameter int DATA_W = 8,
    parameter int LEN_W  = 4,
    parameter int ACC_W  = 12
) (
    input  logic              clkb,
    input  logic              rst,
    input  logic              i_start,
    input  logic [LEN_W-1:0]  i_len,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_product,
    input  logic              i_ack,
    output logic              o_busy,
    output logic              o_done,
    output logic [ACC_W-1:0]  o_sum
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    // A length field of zero encodes the longest run, 2^LEN_W products,
    // which is why the countdown register is one bit wider than i_len.
    localparam logic [LEN_W:0] RUN_MAX  = {1'b1, {LEN_W{1'b0}}};
    localparam logic [LEN_W:0] RUN_LAST = (LEN_W+1)'(1);

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [LEN_W:0]     remaining_q, remaining_d;
    logic [ACC_W-1:0]   sum_q, sum_d;

    logic [LEN_W:0]     runLen;
    logic [ACC_W-1:0]   productExt;
    logic [ACC_W-1:0]   accNext;

    // Run length as loaded into the countdown, and the running sum including
    // the product on the bus this cycle (zero-extended, modulo 2^ACC_W).
    always_comb begin
        runLen     = (i_len == '0) ? RUN_MAX : {1'b0, i_len};
        productExt = {{(ACC_W-DATA_W){1'b0}}, i_product};
        accNext    = acc_q + productExt;
    end

    // Next-state logic: start loads the run, each valid product counts down,
    // the final product latches the result, and ack returns to idle.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        remaining_d = remaining_q;
        sum_d       = sum_q;
        unique case (state_q)
            IDLE: begin
                if (i_start) begin
                    acc_d       = '0;
                    remaining_d = runLen;
                    state_d     = ACCUM;
                end
            end
            ACCUM: begin
                if (i_valid) begin
                    acc_d       = accNext;
                    remaining_d = remaining_q - RUN_LAST;
                    if (remaining_q == RUN_LAST) begin
                        sum_d   = accNext;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                // A start arriving together with ack is deliberately dropped;
                // the controller must present it again once we are idle.
                if (i_ack) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any partial run at once.
    always_ff @(posedge clkb or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            remaining_q <= '0;
            sum_q       <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            remaining_q <= remaining_d;
            sum_q       <= sum_d;
        end
    end

    // Status flags come straight from the registered state so they are
    // glitch-free and mutually exclusive.
    always_comb begin
        o_busy = (state_q == ACCUM);
        o_done = (state_q == DONE);
        o_sum  = sum_q;
    end

endmodule
